// File: rtl/pulse_seq_pkg.sv
// Shared types and default constants for the tick pulse sequencer.
package pulse_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_PAUSE,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } state_t;

    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_RST_TICKS   = 8;
    localparam int DEF_PAUSE_TICKS = 1;

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter that stops at zero; times every phase of the sequencer.
module tick_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tick_pulse_sequencer.sv
// Emits a downstream reset, an optional pause, then a train of masked pulses.
module tick_pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int RST_TICKS   = DEF_RST_TICKS,
    parameter int PAUSE_TICKS = DEF_PAUSE_TICKS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [CHANNELS-1:0] ch_mask,
    input  logic [CNT_W-1:0]    pulse_width,
    input  logic [CNT_W-1:0]    pulse_gap,
    input  logic [CNT_W-1:0]    pulse_count,
    output logic                rst_out,
    output logic [CHANNELS-1:0] pulse_out,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    pulse_idx
);

    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_TICKS - 1);
    localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'((PAUSE_TICKS > 0) ? PAUSE_TICKS - 1 : 0);

    // Counter is loaded with length-1 so the zero flag marks a phase's last cycle.
    function automatic logic [CNT_W-1:0] dur_load(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    state_t              state;
    logic [CHANNELS-1:0] cap_mask;
    logic [CNT_W-1:0]    cap_width;
    logic [CNT_W-1:0]    cap_gap;
    logic [CNT_W-1:0]    cap_count;

    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_value;
    logic                cnt_zero;
    logic [CNT_W-1:0]    hi_load;
    logic [CNT_W-1:0]    lo_load;
    logic [CNT_W-1:0]    idx_next;
    logic                last_pulse;

    assign hi_load    = dur_load(cap_width);
    assign lo_load    = dur_load(cap_gap);
    assign idx_next   = pulse_idx + 1'b1;
    assign last_pulse = (cap_count != '0) && (idx_next == cap_count);

    tick_counter #(.CNT_W(CNT_W)) u_tick_counter (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .value (cnt_value),
        .zero  (cnt_zero)
    );

    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = RST_LOAD;
        case (state)
            ST_IDLE: cnt_load = start && !stop;
            ST_RST: begin
                cnt_load  = cnt_zero;
                cnt_value = (PAUSE_TICKS == 0) ? hi_load : PAUSE_LOAD;
            end
            ST_PAUSE, ST_LOW: begin
                cnt_load  = cnt_zero;
                cnt_value = hi_load;
            end
            ST_HIGH: begin
                cnt_load  = cnt_zero;
                cnt_value = lo_load;
            end
            default: cnt_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rst_out   <= 1'b0;
            pulse_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_idx <= '0;
            cap_mask  <= '0;
            cap_width <= '0;
            cap_gap   <= '0;
            cap_count <= '0;
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && stop) begin
                state     <= ST_IDLE;
                rst_out   <= 1'b0;
                pulse_out <= '0;
                busy      <= 1'b0;
                // A pulse finishing on the abort cycle still counts as completed.
                if (state == ST_HIGH && cnt_zero) pulse_idx <= idx_next;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !stop) begin
                            cap_mask  <= ch_mask;
                            cap_width <= pulse_width;
                            cap_gap   <= pulse_gap;
                            cap_count <= pulse_count;
                            pulse_idx <= '0;
                            rst_out   <= 1'b1;
                            busy      <= 1'b1;
                            state     <= ST_RST;
                        end
                    end
                    ST_RST: begin
                        if (cnt_zero) begin
                            rst_out <= 1'b0;
                            if (PAUSE_TICKS == 0) begin
                                pulse_out <= cap_mask;
                                state     <= ST_HIGH;
                            end else begin
                                state <= ST_PAUSE;
                            end
                        end
                    end
                    ST_PAUSE, ST_LOW: begin
                        if (cnt_zero) begin
                            pulse_out <= cap_mask;
                            state     <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (cnt_zero) begin
                            pulse_out <= '0;
                            pulse_idx <= idx_next;
                            if (last_pulse) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                state <= ST_LOW;
                            end
                        end
                    end
                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        rst_out   <= 1'b0;
                        pulse_out <= '0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_pulse_sequencer.sv
// Directed bench: per-cycle segment tables for whole runs, hand sequences for corner cases.
module tb_tick_pulse_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [3:0]  ch_mask;
    logic [15:0] pulse_width;
    logic [15:0] pulse_gap;
    logic [15:0] pulse_count;

    logic        rst_a, busy_a, done_a;
    logic [3:0]  pulse_a;
    logic [15:0] idx_a;
    logic        rst_b, busy_b, done_b;
    logic [3:0]  pulse_b;
    logic [15:0] idx_b;

    always #5 clk = ~clk;

    tick_pulse_sequencer #(.CHANNELS(4), .CNT_W(16), .RST_TICKS(8), .PAUSE_TICKS(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .ch_mask(ch_mask),
        .pulse_width(pulse_width), .pulse_gap(pulse_gap), .pulse_count(pulse_count),
        .rst_out(rst_a), .pulse_out(pulse_a), .busy(busy_a), .done(done_a), .pulse_idx(idx_a)
    );

    tick_pulse_sequencer #(.CHANNELS(4), .CNT_W(16), .RST_TICKS(8), .PAUSE_TICKS(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .ch_mask(ch_mask),
        .pulse_width(pulse_width), .pulse_gap(pulse_gap), .pulse_count(pulse_count),
        .rst_out(rst_b), .pulse_out(pulse_b), .busy(busy_b), .done(done_b), .pulse_idx(idx_b)
    );

    typedef struct {
        int         first;
        int         last;
        logic       start;
        logic       stop;
        logic       rst;
        logic [3:0] pulse;
        logic       busy;
        logic       done;
    } seg_t;

    seg_t segs[32];
    int   nseg;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] obs(input int sel);
        if (sel == 0) return {rst_a, pulse_a, busy_a, done_a};
        return {rst_b, pulse_b, busy_b, done_b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] m, input logic [15:0] w, input logic [15:0] g, input logic [15:0] c);
        ch_mask = m; pulse_width = w; pulse_gap = g; pulse_count = c;
    endtask

    task automatic add(input int f, input int l, input logic st, input logic sp,
                       input logic r, input logic [3:0] p, input logic b, input logic d);
        segs[nseg] = '{f, l, st, sp, r, p, b, d};
        nseg++;
    endtask

    // Cycle 0 is the cycle in which start is presented.
    task automatic run_trace(input int sel, input string tag);
        for (int s = 0; s < nseg; s++) begin
            for (int c = segs[s].first; c <= segs[s].last; c++) begin
                start = segs[s].start;
                stop  = segs[s].stop;
                if (c == 1) cfg(4'b1111, 16'd5, 16'd6, 16'd9);
                chk($sformatf("%s c%0d", tag, c), 32'(obs(sel)),
                    32'({segs[s].rst, segs[s].pulse, segs[s].busy, segs[s].done}));
                step();
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic basic_segs(input logic [3:0] m, input logic busy_start);
        nseg = 0;
        add(0, 0, 1, 0, 0, 4'h0, 0, 0);
        add(1, 4, 0, 0, 1, 4'h0, 1, 0);
        add(5, 5, busy_start, 0, 1, 4'h0, 1, 0);
        add(6, 8, 0, 0, 1, 4'h0, 1, 0);
        add(9, 9, 0, 0, 0, 4'h0, 1, 0);
        add(10, 11, 0, 0, 0, m, 1, 0);
        add(12, 14, 0, 0, 0, 4'h0, 1, 0);
        add(15, 16, 0, 0, 0, m, 1, 0);
        add(17, 19, 0, 0, 0, 4'h0, 1, 0);
        add(20, 21, 0, 0, 0, m, 1, 0);
        add(22, 22, 0, 0, 0, 4'h0, 1, 1);
        add(23, 24, 0, 0, 0, 4'h0, 0, 0);
    endtask

    task automatic pause0_segs(input logic [3:0] m);
        nseg = 0;
        add(0, 0, 1, 0, 0, 4'h0, 0, 0);
        add(1, 8, 0, 0, 1, 4'h0, 1, 0);
        add(9, 10, 0, 0, 0, m, 1, 0);
        add(11, 13, 0, 0, 0, 4'h0, 1, 0);
        add(14, 15, 0, 0, 0, m, 1, 0);
        add(16, 18, 0, 0, 0, 4'h0, 1, 0);
        add(19, 20, 0, 0, 0, m, 1, 0);
        add(21, 21, 0, 0, 0, 4'h0, 1, 1);
        add(22, 23, 0, 0, 0, 4'h0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        cfg(4'h0, 16'd0, 16'd0, 16'd0);
        repeat (2) step();
        chk("reset outs a", 32'(obs(0)), 32'd0);
        chk("reset idx a", 32'(idx_a), 32'd0);
        chk("reset outs b", 32'(obs(1)), 32'd0);
        chk("reset idx b", 32'(idx_b), 32'd0);
        reset = 1'b0;
        step();

        // Basic run, with a start pulse at cycle 5 that must be ignored.
        cfg(4'b0101, 16'd2, 16'd3, 16'd3);
        basic_segs(4'b0101, 1'b1);
        run_trace(0, "basic");
        chk("basic idx", 32'(idx_a), 32'd3);

        // Zero width/gap clamp to one cycle.
        cfg(4'b0101, 16'd0, 16'd0, 16'd2);
        nseg = 0;
        add(0, 0, 1, 0, 0, 4'h0, 0, 0);
        add(1, 8, 0, 0, 1, 4'h0, 1, 0);
        add(9, 9, 0, 0, 0, 4'h0, 1, 0);
        add(10, 10, 0, 0, 0, 4'b0101, 1, 0);
        add(11, 11, 0, 0, 0, 4'h0, 1, 0);
        add(12, 12, 0, 0, 0, 4'b0101, 1, 0);
        add(13, 13, 0, 0, 0, 4'h0, 1, 1);
        add(14, 15, 0, 0, 0, 4'h0, 0, 0);
        run_trace(0, "clamp");
        chk("clamp idx", 32'(idx_a), 32'd2);

        // Continuous mode aborted by stop during the pulse at cycle 20.
        cfg(4'b1010, 16'd1, 16'd1, 16'd0);
        nseg = 0;
        add(0, 0, 1, 0, 0, 4'h0, 0, 0);
        add(1, 8, 0, 0, 1, 4'h0, 1, 0);
        add(9, 9, 0, 0, 0, 4'h0, 1, 0);
        for (int c = 10; c < 20; c++)
            add(c, c, 0, 0, 0, (c % 2 == 0) ? 4'b1010 : 4'h0, 1, 0);
        add(20, 20, 0, 1, 0, 4'b1010, 1, 0);
        add(21, 22, 0, 0, 0, 4'h0, 0, 0);
        run_trace(0, "cont");
        chk("cont idx", 32'(idx_a), 32'd6);

        // start and stop together while idle: stop wins.
        cfg(4'b0101, 16'd2, 16'd3, 16'd3);
        start = 1'b1; stop = 1'b1;
        step();
        chk("startstop busy a", 32'(busy_a), 32'd0);
        chk("startstop busy b", 32'(busy_b), 32'd0);
        chk("startstop rst a", 32'(rst_a), 32'd0);
        start = 1'b0; stop = 1'b0;
        step();
        chk("startstop busy a later", 32'(busy_a), 32'd0);

        // Asynchronous reset in the middle of a run, then a clean restart.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("midrun pulse c11", 32'(pulse_a), 32'b0101);
        step();
        chk("midrun busy c12", 32'(busy_a), 32'd1);
        chk("midrun idx c12", 32'(idx_a), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrun reset outs a", 32'(obs(0)), 32'd0);
        chk("midrun reset idx a", 32'(idx_a), 32'd0);
        chk("midrun reset outs b", 32'(obs(1)), 32'd0);
        step();
        chk("midrun held done", 32'(done_a), 32'd0);
        reset = 1'b0;
        step();
        cfg(4'b0101, 16'd2, 16'd3, 16'd3);
        basic_segs(4'b0101, 1'b0);
        run_trace(0, "restart");
        chk("restart idx", 32'(idx_a), 32'd3);

        // Build without pause: first pulse one cycle earlier.
        cfg(4'b0011, 16'd2, 16'd3, 16'd3);
        pause0_segs(4'b0011);
        run_trace(1, "nopause");
        chk("nopause idx", 32'(idx_b), 32'd3);

        // All-zero mask keeps full timing with silent outputs.
        cfg(4'b0000, 16'd2, 16'd3, 16'd3);
        pause0_segs(4'b0000);
        run_trace(1, "nomask");
        chk("nomask idx", 32'(idx_b), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
